// File: rtl/boot_loader.sv
// boot_loader: streams host words into the I-cache boot port, holding the core in reset until the image ends.
// Optional feature macro BOOT_CHECKSUM_EN: a trailing checksum beat must match the running word sum before release.
module boot_loader #(
  parameter int MAX_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        host_valid,
  input  logic [31:0] host_data,
  input  logic        host_last,
  output logic        host_ready,
  output logic        boot_up,
  output logic [7:0]  boot_addr,
  output logic [31:0] boot_datai,
  output logic        boot_web,
  output logic        boot_done,
  output logic        boot_err,
  output logic [8:0]  word_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FLUSH,
`ifdef BOOT_CHECKSUM_EN
    S_CHECK,
`endif
    S_DONE,
    S_ERR
  } state_t;

  state_t      state_q;
  logic        host_ready_q;
  logic        boot_up_q;
  logic        boot_web_q;
  logic        boot_done_q;
  logic        boot_err_q;
  logic [7:0]  boot_addr_q;
  logic [31:0] boot_datai_q;
  logic [8:0]  word_cnt_q;
  logic [8:0]  word_cnt_d;
  logic        accept;
  logic        overflow;
`ifdef BOOT_CHECKSUM_EN
  logic [31:0] sum_q;
`endif

  assign accept     = host_valid && host_ready_q;
  assign word_cnt_d = word_cnt_q + 9'd1;
  // The write address is the count of words already written, so it needs no separate register.
  assign overflow   = (word_cnt_d == 9'(MAX_WORDS));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      host_ready_q <= 1'b0;
      boot_up_q    <= 1'b0;
      boot_web_q   <= 1'b1;
      boot_done_q  <= 1'b0;
      boot_err_q   <= 1'b0;
      boot_addr_q  <= 8'd0;
      boot_datai_q <= 32'd0;
      word_cnt_q   <= 9'd0;
`ifdef BOOT_CHECKSUM_EN
      sum_q        <= 32'd0;
`endif
    end else begin
      boot_web_q <= 1'b1;
      case (state_q)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            state_q      <= S_LOAD;
            host_ready_q <= 1'b1;
            boot_up_q    <= 1'b1;
            boot_done_q  <= 1'b0;
            boot_err_q   <= 1'b0;
            word_cnt_q   <= 9'd0;
`ifdef BOOT_CHECKSUM_EN
            sum_q        <= 32'd0;
`endif
          end
        end
        S_LOAD: begin
          if (accept) begin
            boot_web_q   <= 1'b0;
            boot_addr_q  <= word_cnt_q[7:0];
            boot_datai_q <= host_data;
            word_cnt_q   <= word_cnt_d;
`ifdef BOOT_CHECKSUM_EN
            sum_q        <= sum_q + host_data;
`endif
            if (host_last) begin
              state_q      <= S_FLUSH;
              host_ready_q <= 1'b0;
            end else if (overflow) begin
              state_q      <= S_ERR;
              host_ready_q <= 1'b0;
              boot_err_q   <= 1'b1;
            end
          end
        end
        S_FLUSH: begin
`ifdef BOOT_CHECKSUM_EN
          state_q      <= S_CHECK;
          host_ready_q <= 1'b1;
`else
          state_q      <= S_DONE;
          boot_up_q    <= 1'b0;
          boot_done_q  <= 1'b1;
`endif
        end
`ifdef BOOT_CHECKSUM_EN
        S_CHECK: begin
          if (accept) begin
            host_ready_q <= 1'b0;
            if (host_data == sum_q) begin
              state_q     <= S_DONE;
              boot_up_q   <= 1'b0;
              boot_done_q <= 1'b1;
            end else begin
              state_q    <= S_ERR;
              boot_err_q <= 1'b1;
            end
          end
        end
`endif
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign host_ready = host_ready_q;
  assign boot_up    = boot_up_q;
  assign boot_addr  = boot_addr_q;
  assign boot_datai = boot_datai_q;
  assign boot_web   = boot_web_q;
  assign boot_done  = boot_done_q;
  assign boot_err   = boot_err_q;
  assign word_cnt   = word_cnt_q;

endmodule
